// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding.
package serial_adder_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = IDLE,
    S_RUN  = RUN,
    S_DONE = DONE
  } state_e;

endpackage

// File: rtl/full_adder.sv
// 1-bit full adder used as the single bit slice of the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full_adder processes one bit per clock,
// LSB first. A result of WIDTH bits takes WIDTH RUN cycles; sum and carry
// are registered and only change on entry to DONE.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  // Counter must hold the value WIDTH without wrapping.
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_psum;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;

  logic             w_fa_sum;
  logic             w_fa_carry;
  logic [WIDTH-1:0] w_psum_next;
  logic             w_last;

  // Operands are shifted right each RUN cycle, so bit 0 is always the
  // current bit.
  full_adder u_fa (
    .a     (r_a[0]),
    .b     (r_b[0]),
    .cin   (r_carry),
    .sum   (w_fa_sum),
    .carry (w_fa_carry)
  );

  // New sum bit enters at the MSB end; after WIDTH shifts bit 0 is in place.
  // Written as shift/OR so it also holds for WIDTH=1.
  assign w_psum_next = (r_psum >> 1) | (w_fa_sum ? (WIDTH'(1) << (WIDTH - 1)) : '0);
  assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));

  // FSM with all datapath state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every register, including the operand and partial-sum
      // registers, is cleared so an abandoned operation leaves no residue.
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_psum  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      carry   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_psum  <= '0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_RUN;
          end
        end

        S_RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_fa_carry;
          r_psum  <= w_psum_next;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            // Last bit is being processed on this edge, so load the
            // outputs from the next-state values.
            sum     <= w_psum_next;
            carry   <= w_fa_carry;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: table-driven WIDTH=8 vectors plus
// hand-written sequences for start-in-RUN, mid-RUN reset and WIDTH=1.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;

  logic       start8;
  logic [7:0] a8, b8;
  logic       cin8;
  logic       busy8, done8, carry8;
  logic [7:0] sum8;

  logic       start1;
  logic       a1, b1, cin1;
  logic       busy1, done1, carry1;
  logic       sum1;

  int n_cmp;
  int n_err;

  logic [7:0] prev_sum8;
  logic       prev_carry8;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       c;
  } vec_t;

  vec_t vecs[8];

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .carry (carry8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .carry (carry1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Start one WIDTH=8 operation and verify latency, hold and result.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [7:0] es, input logic ec);
    int  lat;
    bit  got;
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    // Disturb the inputs; the result in progress must not see this.
    a8 = ~a; b8 = ~b; cin8 = ~c;
    check("busy_after_start", busy8, 1);
    check("done_after_start", done8, 0);
    lat = 0;
    got = 0;
    while (!got && lat < 12) begin
      @(posedge clk); #1;
      lat++;
      if (done8) got = 1;
      else if (lat == 4) begin
        check("sum_hold_in_run", sum8, prev_sum8);
        check("carry_hold_in_run", carry8, prev_carry8);
      end
    end
    check("done_seen", got, 1);
    check("done_latency", lat, 8);
    check("sum", sum8, es);
    check("carry", carry8, ec);
    check("busy_in_done", busy8, 1);
    @(posedge clk); #1;
    check("done_one_cycle", done8, 0);
    check("busy_back_idle", busy8, 0);
    check("sum_hold_idle", sum8, es);
    prev_sum8   = es;
    prev_carry8 = ec;
  endtask

  initial begin
    int         n_done;
    int         done_edge;
    logic [7:0] s_at_done;
    logic       c_at_done;
    logic       w1_a[3];
    logic       w1_b[3];
    logic       w1_c[3];
    logic       w1_s[3];
    logic       w1_co[3];

    n_cmp = 0;
    n_err = 0;

    vecs[0] = '{a: 8'h00, b: 8'h00, cin: 1'b0, s: 8'h00, c: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, s: 8'h00, c: 1'b1};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, s: 8'hFF, c: 1'b1};
    vecs[3] = '{a: 8'h12, b: 8'h34, cin: 1'b0, s: 8'h46, c: 1'b0};
    vecs[4] = '{a: 8'hA5, b: 8'h5A, cin: 1'b1, s: 8'h00, c: 1'b1};
    vecs[5] = '{a: 8'h80, b: 8'h80, cin: 1'b0, s: 8'h00, c: 1'b1};
    vecs[6] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, s: 8'h80, c: 1'b0};
    vecs[7] = '{a: 8'h3C, b: 8'hC3, cin: 1'b0, s: 8'hFF, c: 1'b0};

    w1_a[0] = 1'b1; w1_b[0] = 1'b1; w1_c[0] = 1'b1; w1_s[0] = 1'b1; w1_co[0] = 1'b1;
    w1_a[1] = 1'b0; w1_b[1] = 1'b1; w1_c[1] = 1'b0; w1_s[1] = 1'b1; w1_co[1] = 1'b0;
    w1_a[2] = 1'b1; w1_b[2] = 1'b0; w1_c[2] = 1'b1; w1_s[2] = 1'b0; w1_co[2] = 1'b1;

    rst_n  = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    prev_sum8   = '0;
    prev_carry8 = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_sum", sum8, 0);
    check("rst_carry", carry8, 0);
    check("rst_busy_w1", busy1, 0);
    check("rst_sum_w1", sum1, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven WIDTH=8 vectors.
    for (int i = 0; i < 8; i++) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].c);
    end

    // start re-asserted with new operands during RUN is ignored.
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'hAA; b8 = 8'hFF; cin8 = 1'b1;
    n_done = 0;
    done_edge = 0;
    s_at_done = '0;
    c_at_done = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (e == 3) start8 = 1'b0;
      if (done8) begin
        n_done++;
        if (n_done == 1) begin
          done_edge = e;
          s_at_done = sum8;
          c_at_done = carry8;
        end
      end
    end
    check("runstart_done_count", n_done, 1);
    check("runstart_latency", done_edge, 8);
    check("runstart_sum", s_at_done, 8'h46);
    check("runstart_carry", c_at_done, 0);
    check("runstart_busy_idle", busy8, 0);

    // Reset asserted in RUN after four bits have been processed.
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy8, 0);
    check("midrst_done", done8, 0);
    check("midrst_sum", sum8, 0);
    check("midrst_carry", carry8, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #1;
      if (done8 || busy8) n_done++;
    end
    check("midrst_no_done", n_done, 0);
    prev_sum8   = '0;
    prev_carry8 = 1'b0;
    run8(8'h05, 8'h03, 1'b0, 8'h08, 1'b0);

    // WIDTH=1: RUN lasts one edge.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a1 = w1_a[i]; b1 = w1_b[i]; cin1 = w1_c[i]; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      a1 = ~a1; b1 = ~b1; cin1 = ~cin1;
      check("w1_busy_run", busy1, 1);
      check("w1_done_run", done1, 0);
      @(posedge clk); #1;
      check("w1_done", done1, 1);
      check("w1_sum", sum1, w1_s[i]);
      check("w1_carry", carry1, w1_co[i]);
      @(posedge clk); #1;
      check("w1_done_clear", done1, 0);
      check("w1_busy_idle", busy1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
